text_console_writer: RTL and testbench

Character-cell text console that owns the screen's code buffer: accepts 16-bit character codes from the CPU over a valid/ready stream and interprets control codes (CR, LF, BS, FF). It maintains the cursor, auto-wrap and hardware scroll. It serves the per-cell code to the VGA character renderer through a registered read port addressed by cell column/row, which the renderer derives as xpos[9:4] and ypos[8:4].

---
 rtl/console_pkg.sv | 34 +++
 rtl/console_ram.sv | 40 ++++
 rtl/text_console_writer.sv | 188 ++++++++++++++++++
 tb/tb_text_console_writer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Shared constants, control codes, FSM states and row arithmetic for the
// character-cell text console.
package console_pkg;

   localparam int COLS_DEF   = 40;
   localparam int ROWS_DEF   = 25;
   localparam int CODE_W_DEF = 16;
   localparam logic [15:0] FILL_DEF = 16'h0020;

   localparam logic [15:0] CC_CR = 16'h000D;
   localparam logic [15:0] CC_LF = 16'h000A;
   localparam logic [15:0] CC_BS = 16'h0008;
   localparam logic [15:0] CC_FF = 16'h000C;

   typedef enum logic [1:0] {
      CLEAR  = 2'd0,
      IDLE   = 2'd1,
      SCROLL = 2'd2
   } state_t;

   // Logical row plus top_row, folded back into 0..rows-1.
   function automatic logic [4:0] row_wrap(input logic [4:0] lrow,
                                           input logic [4:0] top,
                                           input logic [5:0] rows);
      logic [5:0] sum_s;
      sum_s = {1'b0, lrow} + {1'b0, top};
      if (sum_s >= rows) begin
         row_wrap = 5'(sum_s - rows);
      end else begin
         row_wrap = sum_s[4:0];
      end
   endfunction

endpackage

// File: rtl/console_ram.sv
// Simple dual-port code buffer: one write port, one registered read port
// with read-before-write behaviour on a same-cell collision.
module console_ram
   import console_pkg::*;
#(
   parameter int DEPTH = COLS_DEF * ROWS_DEF,
   parameter int WIDTH = CODE_W_DEF,
   parameter int AW    = $clog2(COLS_DEF * ROWS_DEF)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [WIDTH-1:0] rdata_r;

   // Write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Registered read; nonblocking update of mem_r yields the old value on collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_r <= '0;
      end else begin
         rdata_r <= mem_r[raddr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/text_console_writer.sv
// Text console: interprets a character stream into a circular row buffer,
// tracks cursor / top_row, and serves cells to the renderer.
module text_console_writer
   import console_pkg::*;
#(
   parameter int                COLS   = COLS_DEF,
   parameter int                ROWS   = ROWS_DEF,
   parameter int                CODE_W = CODE_W_DEF,
   parameter logic [CODE_W-1:0] FILL   = CODE_W'(FILL_DEF)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ch_valid,
   input  logic [CODE_W-1:0] ch_data,
   output logic              ch_ready,
   input  logic [5:0]        rd_col,
   input  logic [4:0]        rd_row,
   output logic [CODE_W-1:0] rd_code,
   output logic [5:0]        cur_col,
   output logic [4:0]        cur_row,
   output logic              busy
);

   localparam int CELLS = COLS * ROWS;
   localparam int AW    = $clog2(CELLS);
   localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
   localparam logic [AW-1:0] LAST_FILL_COL = AW'(COLS - 1);
   localparam logic [5:0]    LAST_COL  = 6'(COLS - 1);
   localparam logic [4:0]    LAST_ROW  = 5'(ROWS - 1);

   function automatic logic [AW-1:0] cell_addr(input logic [4:0] prow, input logic [5:0] col);
      cell_addr = AW'(prow) * AW'(COLS) + AW'(col);
   endfunction

   state_t            state_r, state_s;
   logic [5:0]        col_r, col_s;
   logic [4:0]        row_r, row_s;
   logic [4:0]        top_r, top_s;
   logic [4:0]        scr_row_r, scr_row_s;
   logic [AW-1:0]     fill_r, fill_s;
   logic              ready_r;
   logic              rd_oor_r, rd_oor_s;
   logic              nl_s;
   logic              we_s;
   logic [AW-1:0]     waddr_s;
   logic [CODE_W-1:0] wdata_s;
   logic [4:0]        cur_phys_s;
   logic [4:0]        rd_phys_s;
   logic [AW-1:0]     raddr_s;
   logic [CODE_W-1:0] ram_q_s;

   assign cur_phys_s = row_wrap(row_r, top_r, 6'(ROWS));
   assign rd_phys_s  = row_wrap(rd_row, top_r, 6'(ROWS));
   assign rd_oor_s   = (rd_col >= 6'(COLS)) || (rd_row >= 5'(ROWS));
   assign raddr_s    = rd_oor_s ? '0 : cell_addr(rd_phys_s, rd_col);

   // Next-state, cursor/scroll bookkeeping and the single RAM write per cycle.
   always_comb begin
      state_s   = state_r;
      col_s     = col_r;
      row_s     = row_r;
      top_s     = top_r;
      scr_row_s = scr_row_r;
      fill_s    = fill_r;
      nl_s      = 1'b0;
      we_s      = 1'b0;
      waddr_s   = cell_addr(cur_phys_s, col_r);
      wdata_s   = FILL;
      case (state_r)
         CLEAR: begin
            we_s    = 1'b1;
            waddr_s = fill_r;
            if (fill_r == LAST_CELL) begin
               state_s = IDLE;
               fill_s  = '0;
            end else begin
               fill_s = fill_r + AW'(1);
            end
         end
         SCROLL: begin
            we_s    = 1'b1;
            waddr_s = cell_addr(scr_row_r, 6'd0) + fill_r;
            if (fill_r == LAST_FILL_COL) begin
               state_s = IDLE;
               fill_s  = '0;
            end else begin
               fill_s = fill_r + AW'(1);
            end
         end
         IDLE: begin
            if (ch_valid) begin
               case (ch_data)
                  CODE_W'(CC_CR): col_s = 6'd0;
                  CODE_W'(CC_LF): nl_s  = 1'b1;
                  CODE_W'(CC_BS): begin
                     if (col_r != 6'd0) begin
                        col_s   = col_r - 6'd1;
                        we_s    = 1'b1;
                        waddr_s = cell_addr(cur_phys_s, col_r - 6'd1);
                     end else begin
                        col_s = col_r;
                     end
                  end
                  CODE_W'(CC_FF): begin
                     top_s   = 5'd0;
                     col_s   = 6'd0;
                     row_s   = 5'd0;
                     fill_s  = '0;
                     state_s = CLEAR;
                  end
                  default: begin
                     we_s    = 1'b1;
                     wdata_s = ch_data;
                     if (col_r == LAST_COL) begin
                        col_s = 6'd0;
                        nl_s  = 1'b1;
                     end else begin
                        col_s = col_r + 6'd1;
                     end
                  end
               endcase
            end else begin
               state_s = IDLE;
            end
         end
         default: state_s = CLEAR;
      endcase

      // Newline on the bottom row rotates the buffer and blanks the row that wrapped around.
      if (nl_s) begin
         if (row_r < LAST_ROW) begin
            row_s = row_r + 5'd1;
         end else begin
            row_s     = LAST_ROW;
            top_s     = (top_r == LAST_ROW) ? 5'd0 : top_r + 5'd1;
            scr_row_s = top_r;
            fill_s    = '0;
            state_s   = SCROLL;
         end
      end else begin
         row_s = row_s;
      end
   end

   // State, cursor, scroll and read-flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= CLEAR;
         col_r     <= 6'd0;
         row_r     <= 5'd0;
         top_r     <= 5'd0;
         scr_row_r <= 5'd0;
         fill_r    <= '0;
         ready_r   <= 1'b0;
         rd_oor_r  <= 1'b0;
      end else begin
         state_r   <= state_s;
         col_r     <= col_s;
         row_r     <= row_s;
         top_r     <= top_s;
         scr_row_r <= scr_row_s;
         fill_r    <= fill_s;
         ready_r   <= (state_s == IDLE);
         rd_oor_r  <= rd_oor_s;
      end
   end

   console_ram #(
      .DEPTH (CELLS),
      .WIDTH (CODE_W),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we_s),
      .waddr (waddr_s),
      .wdata (wdata_s),
      .raddr (raddr_s),
      .rdata (ram_q_s)
   );

   assign rd_code  = rd_oor_r ? FILL : ram_q_s;
   assign ch_ready = ready_r;
   assign busy     = ~ready_r;
   assign cur_col  = col_r;
   assign cur_row  = row_r;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer; reads are checked by a scoreboard
// monitor one cycle after the address is presented.
module tb_text_console_writer;

   logic        clk;
   logic        rst_n;
   logic        ch_valid;
   logic [15:0] ch_data;
   logic        ch_ready;
   logic [5:0]  rd_col;
   logic [4:0]  rd_row;
   logic [15:0] rd_code;
   logic [5:0]  cur_col;
   logic [4:0]  cur_row;
   logic        busy;

   int errors = 0;
   int checks = 0;

   logic        rd_en   = 1'b0;
   logic        rd_pend = 1'b0;
   logic [15:0] exp_q [$];
   string       name_q [$];

   text_console_writer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ch_valid (ch_valid),
      .ch_data  (ch_data),
      .ch_ready (ch_ready),
      .rd_col   (rd_col),
      .rd_row   (rd_row),
      .rd_code  (rd_code),
      .cur_col  (cur_col),
      .cur_row  (cur_row),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Address accepted at a posedge -> rd_code compared at the following negedge.
   always @(posedge clk) rd_pend <= rd_en;

   always @(negedge clk) begin
      if (rd_pend) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got read with no expectation, code %0h", rd_code);
         end else begin
            check(name_q.pop_front(), 32'(rd_code), 32'(exp_q.pop_front()));
         end
      end
   end

   function automatic logic [15:0] fcode(input int r, input int c);
      return 16'h1000 + 16'(r * 64 + c);
   endfunction

   task automatic rd(input int r, input int c, input logic [15:0] e, input string nm);
      rd_row = 5'(r);
      rd_col = 6'(c);
      rd_en  = 1'b1;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic send(input logic [15:0] c);
      int n;
      n = 0;
      ch_valid = 1'b1;
      ch_data  = c;
      while (!ch_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: code %0h never accepted after %0d cycles", c, n);
      end
      @(negedge clk);
      ch_valid = 1'b0;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (!ch_ready && n < 3000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic check_cursor(input string nm, input int c, input int r);
      check({nm, "_col"}, 32'(cur_col), 32'(c));
      check({nm, "_row"}, 32'(cur_row), 32'(r));
   endtask

   int nbusy;

   initial begin
      rst_n    = 1'b0;
      ch_valid = 1'b0;
      ch_data  = 16'h0000;
      rd_row   = 5'd0;
      rd_col   = 6'd0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(ch_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_rd_code", 32'(rd_code), 32'd0);
      check_cursor("rst_cursor", 0, 0);
      rst_n = 1'b1;
      count_busy(nbusy);
      check("init_clear_cycles", 32'(nbusy), 32'd1000);
      check_cursor("init_cursor", 0, 0);
      rd(24, 39, 16'h0020, "init_cell_24_39");
      rd(0, 40, 16'h0020, "oor_col");
      rd(25, 0, 16'h0020, "oor_row");

      send(16'h0041);
      check_cursor("first_char", 1, 0);
      rd(0, 0, 16'h0041, "first_char_cell");

      send(16'h000D);
      for (int i = 0; i < 40; i++) send(16'h0030 + 16'(i));
      check_cursor("row0_wrap", 0, 1);
      send(16'h0141);
      check_cursor("after_41st", 1, 1);
      rd(0, 0, 16'h0030, "row0_col0");
      rd(0, 39, 16'h0057, "row0_col39");
      rd(1, 0, 16'h0141, "wide_code_cell");

      send(16'h000D);
      send(16'h0008);
      check_cursor("bs_col0", 0, 1);
      rd(1, 0, 16'h0141, "bs_col0_cell");
      send(16'h0041);
      send(16'h0042);
      send(16'h0043);
      send(16'h0008);
      check_cursor("bs_col3", 2, 1);
      rd(1, 2, 16'h0020, "bs_fill_cell");
      rd(1, 1, 16'h0042, "bs_neighbor");
      send(16'h0044);
      send(16'h0045);
      send(16'h0046);
      check_cursor("pre_cr", 5, 1);
      send(16'h000D);
      check_cursor("cr_col5", 0, 1);

      send(16'h000C);
      count_busy(nbusy);
      check("ff_clear_cycles", 32'(nbusy), 32'd1000);
      check_cursor("ff_cursor", 0, 0);
      rd(1, 1, 16'h0020, "ff_cell_1_1");
      rd(0, 0, 16'h0020, "ff_cell_0_0");

      for (int r = 0; r < 24; r++)
         for (int c = 0; c < 40; c++) send(fcode(r, c));
      for (int c = 0; c < 39; c++) send(fcode(24, c));
      check_cursor("filled", 39, 24);
      rd(24, 38, fcode(24, 38), "pre_scroll_24_38");
      send(16'h000D);
      send(16'h000A);
      count_busy(nbusy);
      check("scroll_cycles", 32'(nbusy), 32'd40);
      check_cursor("scroll_cursor", 0, 24);
      rd(0, 0, fcode(1, 0), "scr_row0_col0");
      rd(0, 39, fcode(1, 39), "scr_row0_col39");
      rd(12, 17, fcode(13, 17), "scr_row12_col17");
      rd(22, 5, fcode(23, 5), "scr_row22_col5");
      rd(23, 0, fcode(24, 0), "scr_row23_col0");
      rd(23, 39, 16'h0020, "scr_row23_col39");
      for (int c = 0; c < 40; c++) rd(24, c, 16'h0020, "scr_row24_blank");

      send(16'h000A);
      repeat (5) @(negedge clk);
      check("mid_scroll_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_ready", 32'(ch_ready), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd1);
      check("rst_mid_rd_code", 32'(rd_code), 32'd0);
      check_cursor("rst_mid_cursor", 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      count_busy(nbusy);
      check("rst_reclear_cycles", 32'(nbusy), 32'd1000);
      rd(0, 0, 16'h0020, "reclear_cell_0_0");
      rd(10, 20, 16'h0020, "reclear_cell_10_20");

      repeat (3) @(negedge clk);
      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
